// File: rtl/rx_fsm_pkg.sv
// ============================================================================
// Module : uart_pkg
// Desc   : Shared UART types and frame constants for the receiver slice.
//          Majority voting is enabled by UART_RX_MAJORITY_EN.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_EVEN   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int MIN_DIVISOR   = 4;
  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_fsm_if.sv
// ============================================================================
// Module : rx_fsm_if
// Desc   : Serial line in, parallel word and status flags out.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

interface rx_fsm_if;
  logic       RX;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  // master drives the line and consumes results; slave is the receiver
  modport master (output RX, input data_out, rx_valid, parity_err, frame_err, busy);
  modport slave  (input RX, output data_out, rx_valid, parity_err, frame_err, busy);
endinterface

`default_nettype wire

// File: rtl/rx_fsm_sync.sv
// ============================================================================
// Module : rx_sync
// Desc   : Two-flop synchronizer, asynchronous active-low reset to 1.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/rx_fsm.sv
// ============================================================================
// Module : rx_fsm
// Desc   : UART receiver (start, LSB-first data, parity, stop), centre sampled.
//          Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module rx_fsm
  import uart_pkg::*;
#(
  parameter int divisor     = 10,
  parameter int rx_num_bits = 8,
  parameter int parity      = PARITY_EVEN
) (
  input  logic       clk,
  input  logic       RSTn,
  rx_fsm_if.slave    bus
);

  localparam logic [31:0] c_half     = 32'(divisor / 2 - 1);
  localparam logic [31:0] c_full     = 32'(divisor - 1);
  localparam logic [31:0] c_last_bit = 32'(rx_num_bits - 1);

  if (divisor < MIN_DIVISOR || rx_num_bits < MIN_DATA_BITS ||
      rx_num_bits > MAX_DATA_BITS) begin : g_bad_param
    $error("rx_fsm: divisor must be >= 4 and rx_num_bits in 5..8");
  end

  rx_state_t   state_q;
  logic [31:0] baud_q;
  logic [3:0]  bit_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        perr_q;
  logic        ferr_q;
  logic        busy_q;
  logic        rx_s_d_q;

  logic rx_s;
  logic w_sample;
  logic w_exp_par;

  rx_sync u_sync (
    .clk   (clk),
    .rst_n (RSTn),
    .d_i   (bus.RX),
    .q_o   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rx_s from counts S-1 and S-2; the live rx_s is count S
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign w_sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign w_sample = rx_s;
`endif

  // shift_q bits above rx_num_bits stay 0, so full-width XOR is the word parity
  assign w_exp_par = (parity == PARITY_ODD) ? ~^shift_q : ^shift_q;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      rx_s_d_q <= 1'b1;
    end else begin
      rx_s_d_q <= rx_s;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (rx_s_d_q && !rx_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
            shift_q <= '0;
          end
        end

        START: begin
          if (baud_q == c_half) begin
            baud_q <= '0;
            if (!w_sample) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 32'd1;
          end
        end

        DATA: begin
          if (baud_q == c_full) begin
            baud_q                <= '0;
            shift_q[bit_q[2:0]]   <= w_sample;
            bit_q                 <= bit_q + 4'd1;
            if ({28'd0, bit_q} == c_last_bit) begin
              state_q <= PARITY;
            end
          end else begin
            baud_q <= baud_q + 32'd1;
          end
        end

        PARITY: begin
          if (baud_q == c_full) begin
            baud_q  <= '0;
            par_q   <= w_sample;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + 32'd1;
          end
        end

        STOP: begin
          if (baud_q == c_full) begin
            baud_q  <= '0;
            data_q  <= shift_q;
            perr_q  <= par_q ^ w_exp_par;
            ferr_q  <= !w_sample;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 32'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire
